// File: rtl/ws2812_serializer_if.sv
// Read-port handshake between the pixel FIFO and the WS2812 serializer.
interface ws2812_serializer_if;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ws2812_serializer.sv
// Serializes 24-bit pixel words MSB first onto a WS2812 chain as NRZ
// pulse-width-coded bits, closing each frame with a low latch gap.
module ws2812_serializer #(
   parameter int T0H    = 16,
   parameter int T1H    = 32,
   parameter int TBIT   = 50,
   parameter int TRESET = 2000,
   parameter int CW     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_n,
   ws2812_serializer_if.slave pix,
   output logic               led_out,
   output logic               busy,
   output logic               frame_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_LATCH = 2'd2
   } state_t;

   localparam logic [CW-1:0] LP_BIT_LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] LP_RST_LAST = CW'(TRESET - 1);
   localparam logic [CW-1:0] LP_T0H      = CW'(T0H);
   localparam logic [CW-1:0] LP_T1H      = CW'(T1H);
   localparam logic [CW-1:0] LP_CNT_ONE  = CW'(1);

   state_t        r_state;
   logic [23:0]   r_shift;
   logic [4:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic          r_led;
   logic          r_busy;
   logic          r_frame_done;

   state_t        w_state_nxt;
   logic [23:0]   w_shift_nxt;
   logic [4:0]    w_idx_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_thigh;
   logic          w_ready;
   logic          w_xfer;
   logic          w_led_nxt;
   logic          w_busy_nxt;
   logic          w_fd_nxt;

   // Ready only when idle or on the final cycle of the last bit, so chained pixels have no gap
   assign w_ready = !rst && clear_n &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_SHIFT) && (r_idx == 5'd0) && (r_cnt == LP_BIT_LAST)));
   assign w_xfer       = pix.in_valid && w_ready;
   assign pix.in_ready = w_ready;

   assign w_thigh    = r_shift[23] ? LP_T1H : LP_T0H;
   assign w_led_nxt  = clear_n && (r_state == S_SHIFT) && (r_cnt < w_thigh);
   assign w_fd_nxt   = clear_n && (r_state == S_LATCH) && (r_cnt == LP_RST_LAST);
   assign w_busy_nxt = (r_state != S_IDLE) && (w_state_nxt != S_IDLE);

   assign led_out    = r_led;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

   // Next-state, shift and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      if (!clear_n) begin
         w_state_nxt = S_IDLE;
         w_shift_nxt = 24'd0;
         w_idx_nxt   = 5'd0;
         w_cnt_nxt   = {CW{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  w_state_nxt = S_SHIFT;
                  w_shift_nxt = pix.in_data;
                  w_idx_nxt   = 5'd23;
                  w_cnt_nxt   = {CW{1'b0}};
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_SHIFT: begin
               if (r_cnt == LP_BIT_LAST) begin
                  w_cnt_nxt = {CW{1'b0}};
                  if (r_idx != 5'd0) begin
                     w_idx_nxt   = r_idx - 5'd1;
                     w_shift_nxt = {r_shift[22:0], 1'b0};
                  end else if (w_xfer) begin
                     w_shift_nxt = pix.in_data;
                     w_idx_nxt   = 5'd23;
                  end else begin
                     w_state_nxt = S_LATCH;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + LP_CNT_ONE;
               end
            end
            S_LATCH: begin
               if (r_cnt == LP_RST_LAST) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = {CW{1'b0}};
               end else begin
                  w_cnt_nxt = r_cnt + LP_CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = {CW{1'b0}};
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_shift      <= 24'd0;
         r_idx        <= 5'd0;
         r_cnt        <= {CW{1'b0}};
         r_led        <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_idx        <= w_idx_nxt;
         r_cnt        <= w_cnt_nxt;
         r_led        <= w_led_nxt;
         r_busy       <= w_busy_nxt;
         r_frame_done <= w_fd_nxt;
      end
   end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Randomized self-checking bench for ws2812_serializer: a timeline model of
// pixels, chaining and latch gaps predicts every output cycle by cycle.
module tb_ws2812_serializer;
   localparam int T0H = 16, T1H = 32, TBIT = 50, TRESET = 2000;
   localparam int PIX = 24 * TBIT;
   localparam int MAXC = 40000;
   localparam int NW = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear_n = 1'b1;
   logic clear2_n = 1'b1;
   logic led_out, busy, frame_done;
   logic led2, busy2, fd2;

   ws2812_serializer_if pix ();
   ws2812_serializer_if pix2 ();

   ws2812_serializer dut (
      .clk(clk), .rst(rst), .clear_n(clear_n), .pix(pix),
      .led_out(led_out), .busy(busy), .frame_done(frame_done)
   );

   ws2812_serializer #(.T0H(1), .T1H(2), .TBIT(3), .TRESET(1), .CW(16)) dut2 (
      .clk(clk), .rst(rst), .clear_n(clear2_n), .pix(pix2),
      .led_out(led2), .busy(busy2), .frame_done(fd2)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit exp_led [MAXC];
   bit exp_rdy [MAXC];
   bit exp_fd  [MAXC];
   bit exp_act [MAXC];
   logic [23:0] w_arr [NW];
   int a_arr [NW];
   int e_arr [NW];
   int n_latch;
   int ncyc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, want);
      end
   endtask

   task automatic mark_pixel(input int e, input logic [23:0] w);
      for (int n = e; n < e + PIX; n++) begin
         exp_act[n] = 1'b1;
         exp_rdy[n] = (n == e + PIX - 1);
      end
      for (int m = 0; m < PIX; m++) begin
         int b;
         b = w[23 - m / TBIT] ? T1H : T0H;
         exp_led[e + 1 + m] = ((m % TBIT) < b);
      end
   endtask

   task automatic mark_latch(input int p);
      for (int n = p; n < p + TRESET; n++) begin
         exp_act[n] = 1'b1;
         exp_rdy[n] = 1'b0;
      end
      exp_fd[p + TRESET] = 1'b1;
      n_latch++;
   endtask

   // Timeline of the first nw words: acceptance edges, chaining and latch gaps
   task automatic build_model(input int nw);
      int t, e, pend, v;
      for (int n = 0; n < MAXC; n++) begin
         exp_led[n] = 1'b0; exp_rdy[n] = 1'b1; exp_fd[n] = 1'b0; exp_act[n] = 1'b0;
      end
      n_latch = 0;
      t = 1;
      pend = 0;
      for (int i = 0; i < nw; i++) begin
         v = a_arr[i] + 1;
         if (i > 0 && v <= pend) begin
            e = pend;
         end else begin
            if (i > 0) begin
               mark_latch(pend);
               t = pend + TRESET + 1;
            end
            e = (v > t) ? v : t;
         end
         e_arr[i] = e;
         mark_pixel(e, w_arr[i]);
         pend = e + PIX;
      end
      mark_latch(pend);
      ncyc = pend + TRESET + 20;
   endtask

   // Drives one word into the selected DUT while idle and checks its full waveform
   task automatic expect_pixel(input int sel, input logic [23:0] w,
                               input int t0, input int t1, input int tb);
      if (sel == 0) begin pix.in_valid = 1'b1; pix.in_data = w; end
      else begin pix2.in_valid = 1'b1; pix2.in_data = w; end
      @(negedge clk);
      check_val("acc_rdy", 32'((sel == 0) ? pix.in_ready : pix2.in_ready), 32'd1);
      @(posedge clk);
      #1;
      pix.in_valid = 1'b0;
      pix2.in_valid = 1'b0;
      @(negedge clk);
      check_val("pix_first", 32'((sel == 0) ? led_out : led2), 32'd0);
      for (int m = 0; m < 24 * tb; m++) begin
         int b;
         @(negedge clk);
         b = w[23 - m / tb] ? t1 : t0;
         check_val("pix_led", 32'((sel == 0) ? led_out : led2), 32'((m % tb) < b));
      end
   endtask

   initial begin
      int qi, fd_obs, hi_obs, got_fd;
      logic xfer;
      logic [23:0] w;
      pix.in_valid = 1'b0; pix.in_data = 24'd0;
      pix2.in_valid = 1'b0; pix2.in_data = 24'd0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_led", 32'(led_out), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_fd", 32'(frame_done), 32'd0);
      check_val("rst_rdy", 32'(pix.in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Word schedule: single pixel, a three-word burst, a late word, then random traffic
      w_arr[0] = 24'hA00000; a_arr[0] = 5;
      w_arr[1] = 24'hFFFFFF; a_arr[1] = 3300;
      w_arr[2] = 24'h000000; a_arr[2] = 3300;
      w_arr[3] = 24'h5A5A5A; a_arr[3] = 3300;
      build_model(4);
      w_arr[4] = 24'h123456; a_arr[4] = e_arr[3] + PIX + 9;
      build_model(5);
      a_arr[5] = e_arr[4] + $urandom_range(600, 1400);
      w_arr[5] = 24'($urandom);
      for (int i = 6; i < NW; i++) begin
         a_arr[i] = a_arr[i-1] + $urandom_range(0, 1400);
         w_arr[i] = 24'($urandom);
      end
      build_model(NW);

      qi = 0;
      fd_obs = 0;
      for (int n = 0; n < ncyc; n++) begin
         if (qi < NW && a_arr[qi] <= n) begin
            pix.in_valid = 1'b1; pix.in_data = w_arr[qi];
         end else begin
            pix.in_valid = 1'b0; pix.in_data = 24'($urandom);
         end
         @(negedge clk);
         check_val("led", 32'(led_out), 32'(exp_led[n]));
         check_val("rdy", 32'(pix.in_ready), 32'(exp_rdy[n]));
         check_val("fd", 32'(frame_done), 32'(exp_fd[n]));
         if (n > 0) check_val("busy", 32'(busy), 32'(exp_act[n-1] && exp_act[n]));
         if (frame_done) fd_obs++;
         xfer = pix.in_valid && pix.in_ready;
         @(posedge clk);
         #1;
         if (xfer) qi++;
      end
      pix.in_valid = 1'b0;
      check_val("words_taken", 32'(qi), 32'(NW));
      check_val("fd_count", 32'(fd_obs), 32'(n_latch));

      // Synchronous abort at bit 12, counter 20
      w = 24'($urandom);
      pix.in_valid = 1'b1; pix.in_data = w;
      @(posedge clk);
      #1 pix.in_valid = 1'b0;
      repeat (12 * TBIT + 20) @(posedge clk);
      #1;
      check_val("clr_pre_led", 32'(led_out), 32'(w[11]));
      clear_n = 1'b0;
      @(negedge clk);
      check_val("clr_rdy", 32'(pix.in_ready), 32'd0);
      @(posedge clk);
      #1 clear_n = 1'b1;
      @(negedge clk);
      check_val("clr_led", 32'(led_out), 32'd0);
      check_val("clr_busy", 32'(busy), 32'd0);
      check_val("clr_idle_rdy", 32'(pix.in_ready), 32'd1);
      fd_obs = 0;
      hi_obs = 0;
      for (int i = 0; i < TRESET + 200; i++) begin
         @(negedge clk);
         if (frame_done) fd_obs++;
         if (led_out) hi_obs++;
      end
      check_val("clr_no_fd", 32'(fd_obs), 32'd0);
      check_val("clr_no_led", 32'(hi_obs), 32'd0);
      @(posedge clk);
      #1;
      expect_pixel(0, 24'($urandom), T0H, T1H, TBIT);
      got_fd = 0;
      for (int i = 0; i < TRESET + 10 && got_fd == 0; i++) begin
         @(negedge clk);
         if (frame_done) got_fd = 1;
      end
      check_val("clr_fd_end", 32'(got_fd), 32'd1);

      // Asynchronous reset during the high phase of bit 5
      @(posedge clk);
      #1;
      w = 24'($urandom);
      pix.in_valid = 1'b1; pix.in_data = w;
      @(posedge clk);
      #1 pix.in_valid = 1'b0;
      repeat (5 * TBIT + 5) @(posedge clk);
      #3;
      check_val("rstm_pre_led", 32'(led_out), 32'd1);
      rst = 1'b1;
      #1;
      check_val("rstm_led", 32'(led_out), 32'd0);
      check_val("rstm_rdy", 32'(pix.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("rstm_hold_rdy", 32'(pix.in_ready), 32'd0);
         check_val("rstm_hold_busy", 32'(busy), 32'd0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rstm_rel_rdy", 32'(pix.in_ready), 32'd1);
      check_val("rstm_rel_led", 32'(led_out), 32'd0);
      @(posedge clk);
      #1;
      expect_pixel(0, 24'($urandom), T0H, T1H, TBIT);

      // Minimal timing parameters on the second instance
      @(posedge clk);
      #1;
      expect_pixel(1, 24'h800001, 1, 2, 3);
      check_val("s_latch_fd", 32'(fd2), 32'd0);
      check_val("s_latch_rdy", 32'(pix2.in_ready), 32'd0);
      check_val("s_latch_led", 32'(led2), 32'd0);
      @(negedge clk);
      check_val("s_fd", 32'(fd2), 32'd1);
      check_val("s_idle_rdy", 32'(pix2.in_ready), 32'd1);
      @(negedge clk);
      check_val("s_fd_pulse", 32'(fd2), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
